// File: rtl/alu.sv
// 32-bit integer ALU for the execute stage of a single-cycle RISC-V datapath.
// result and its flags are purely combinational; result_q/zero_q are a
// registered debug/trace copy with a synchronous active-low clear.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SLTU = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  localparam int unsigned MSB = WIDTH - 1;

  alu_op_e          op;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;
  logic             sum_ovf;
  logic [WIDTH-1:0] diff;
  logic             diff_carry;
  logic             diff_ovf;
  logic             lt_signed;
  logic             lt_unsigned;

  assign op = alu_op_e'(alu_ctrl);

  // Shared adder/subtractor paths; SUB is a + ~b + 1 so its carry-out means "no borrow".
  always_comb begin
    {sum_carry, sum}   = {1'b0, a} + {1'b0, b};
    {diff_carry, diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sum_ovf     = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    diff_ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    // Signed less-than takes the difference sign corrected by overflow,
    // so extreme operands (e.g. MIN - 1) still compare correctly.
    lt_signed   = diff[MSB] ^ diff_ovf;
    lt_unsigned = ~diff_carry;
  end

  // Operation select and flag generation; every output has a default.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD: begin
        result   = sum;
        carry    = sum_carry;
        overflow = sum_ovf;
      end
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[4:0];
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SUB: begin
        result   = diff;
        carry    = diff_carry;
        overflow = diff_ovf;
      end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
      default: result = '0;
    endcase
    zero     = (result == '0);
    negative = result[MSB];
  end

  // Registered trace copy; reset wins over capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: combinational ops/flags, boundary
// cases, and the registered trace copy with synchronous reset.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic [31:0] result_q;
  logic        zero_q;

  int unsigned tests;
  int unsigned fails;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } vec_t;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .result_q (result_q),
    .zero_q   (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; a = 32'd10; b = 32'd5; alu_ctrl = 3'b010;
    @(posedge clk); #1;
    tests++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) begin
      fails++;
      $display("FAIL reset_regs: got result_q=%h zero_q=%b, expected 00000000 1", result_q, zero_q);
    end
    tests++;
    if (result !== 32'd15 || zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_comb_indep: got result=%h zero=%b, expected 0000000f 0", result, zero);
    end
  endtask

  task automatic test_arith();
    vec_t v[$];
    v.push_back(vec_t'{"add_10_5",  32'd10, 32'd5,  3'b010, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"sub_10_5",  32'd10, 32'd5,  3'b110, 32'd5,  1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back(vec_t'{"sub_20_20", 32'd20, 32'd20, 3'b110, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0});
    v.push_back(vec_t'{"sub_20_10", 32'd20, 32'd10, 3'b110, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back(vec_t'{"add_wrap",  32'hFFFFFFFF, 32'd1, 3'b010, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    foreach (v[i]) begin
      a = v[i].a; b = v[i].b; alu_ctrl = v[i].op; #1;
      tests++;
      if ({result, zero, negative, carry, overflow} !== {v[i].r, v[i].z, v[i].n, v[i].c, v[i].v}) begin
        fails++;
        $display("FAIL %s: got r=%h z=%b n=%b c=%b v=%b, expected r=%h z=%b n=%b c=%b v=%b", v[i].name,
                 result, zero, negative, carry, overflow, v[i].r, v[i].z, v[i].n, v[i].c, v[i].v);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[$];
    v.push_back(vec_t'{"and_10_5",  32'd10, 32'd5, 3'b000, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"or_10_5",   32'd10, 32'd5, 3'b001, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"xor_10_5",  32'd10, 32'd5, 3'b011, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"and_mask",  32'hFFFFFFFF, 32'hF0F0F0F0, 3'b000, 32'hF0F0F0F0, 1'b0, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{"or_ones",   32'hFFFFFFFF, 32'd1, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{"xor_self",  32'h12345678, 32'h12345678, 3'b011, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    foreach (v[i]) begin
      a = v[i].a; b = v[i].b; alu_ctrl = v[i].op; #1;
      tests++;
      if ({result, zero, negative, carry, overflow} !== {v[i].r, v[i].z, v[i].n, v[i].c, v[i].v}) begin
        fails++;
        $display("FAIL %s: got r=%h z=%b n=%b c=%b v=%b, expected r=%h z=%b n=%b c=%b v=%b", v[i].name,
                 result, zero, negative, carry, overflow, v[i].r, v[i].z, v[i].n, v[i].c, v[i].v);
      end
    end
  endtask

  task automatic test_compare();
    vec_t v[$];
    v.push_back(vec_t'{"slt_5_10",    32'd5, 32'd10, 3'b111, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"slt_m1_1",    32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"sltu_m1_1",   32'hFFFFFFFF, 32'd1, 3'b101, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"sltu_5_10",   32'd5, 32'd10, 3'b101, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"slt_min_1",   32'h80000000, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"slt_max_m1",  32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"slt_eq",      32'd20, 32'd20, 3'b111, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"sltu_eq",     32'd20, 32'd20, 3'b101, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    foreach (v[i]) begin
      a = v[i].a; b = v[i].b; alu_ctrl = v[i].op; #1;
      tests++;
      if ({result, zero, negative, carry, overflow} !== {v[i].r, v[i].z, v[i].n, v[i].c, v[i].v}) begin
        fails++;
        $display("FAIL %s: got r=%h z=%b n=%b c=%b v=%b, expected r=%h z=%b n=%b c=%b v=%b", v[i].name,
                 result, zero, negative, carry, overflow, v[i].r, v[i].z, v[i].n, v[i].c, v[i].v);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    v.push_back(vec_t'{"sll_1_31",   32'd1, 32'd31, 3'b100, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{"sll_hi_ign", 32'd3, 32'hFFFFFFE1, 3'b100, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"sll_by_32",  32'd1, 32'd32, 3'b100, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"sll_out",    32'h80000001, 32'd1, 3'b100, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{"sll_to_0",   32'h00000002, 32'd31, 3'b100, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    foreach (v[i]) begin
      a = v[i].a; b = v[i].b; alu_ctrl = v[i].op; #1;
      tests++;
      if ({result, zero, negative, carry, overflow} !== {v[i].r, v[i].z, v[i].n, v[i].c, v[i].v}) begin
        fails++;
        $display("FAIL %s: got r=%h z=%b n=%b c=%b v=%b, expected r=%h z=%b n=%b c=%b v=%b", v[i].name,
                 result, zero, negative, carry, overflow, v[i].r, v[i].z, v[i].n, v[i].c, v[i].v);
      end
    end
  endtask

  task automatic test_boundary();
    vec_t v[$];
    v.push_back(vec_t'{"add_max_1",  32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
    v.push_back(vec_t'{"sub_0_1",    32'd0, 32'd1, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{"sub_min_1",  32'h80000000, 32'd1, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1});
    v.push_back(vec_t'{"sub_max_m1", 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
    v.push_back(vec_t'{"add_min_min", 32'h80000000, 32'h80000000, 3'b010, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1});
    foreach (v[i]) begin
      a = v[i].a; b = v[i].b; alu_ctrl = v[i].op; #1;
      tests++;
      if ({result, zero, negative, carry, overflow} !== {v[i].r, v[i].z, v[i].n, v[i].c, v[i].v}) begin
        fails++;
        $display("FAIL %s: got r=%h z=%b n=%b c=%b v=%b, expected r=%h z=%b n=%b c=%b v=%b", v[i].name,
                 result, zero, negative, carry, overflow, v[i].r, v[i].z, v[i].n, v[i].c, v[i].v);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst_n = 1'b1; a = 32'd10; b = 32'd5; alu_ctrl = 3'b010;
    #1;
    tests++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) begin
      fails++;
      $display("FAIL reg_before_edge: got result_q=%h zero_q=%b, expected 00000000 1", result_q, zero_q);
    end
    @(posedge clk); #1;
    tests++;
    if (result_q !== 32'd15 || zero_q !== 1'b0) begin
      fails++;
      $display("FAIL reg_add_10_5: got result_q=%h zero_q=%b, expected 0000000f 0", result_q, zero_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea [3];
    logic [31:0] eb [3];
    logic [2:0]  eo [3];
    logic [31:0] er [3];
    logic        ez [3];
    ea = '{32'd10, 32'd20, 32'd5};
    eb = '{32'd5,  32'd10, 32'd10};
    eo = '{3'b000, 3'b110, 3'b111};
    er = '{32'd0,  32'd10, 32'd1};
    ez = '{1'b1,   1'b0,   1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = ea[i]; b = eb[i]; alu_ctrl = eo[i];
      @(posedge clk); #1;
      tests++;
      if (result_q !== er[i] || zero_q !== ez[i]) begin
        fails++;
        $display("FAIL b2b_%0d: got result_q=%h zero_q=%b, expected %h %b", i, result_q, zero_q, er[i], ez[i]);
      end
    end
    // Reset must override capture of a nonzero result.
    @(negedge clk);
    rst_n = 1'b0; a = 32'd7; b = 32'd8; alu_ctrl = 3'b010;
    @(posedge clk); #1;
    tests++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) begin
      fails++;
      $display("FAIL reset_priority: got result_q=%h zero_q=%b, expected 00000000 1", result_q, zero_q);
    end
    tests++;
    if (result !== 32'd15) begin
      fails++;
      $display("FAIL comb_in_reset: got result=%h, expected 0000000f", result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (result_q !== 32'd15 || zero_q !== 1'b0) begin
      fails++;
      $display("FAIL reg_after_release: got result_q=%h zero_q=%b, expected 0000000f 0", result_q, zero_q);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    alu_ctrl = 3'b000;
    test_reset();
    test_arith();
    test_logic();
    test_compare();
    test_shift();
    test_boundary();
    test_registered();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
